// File: rtl/opb_can_bridge.sv
// OPB slave front-end: decodes bus cycles into one-hot CAN1..CAN4 strobes, ack at RD_LAT+2 (read) / WR_LAT+2 (write).
// Master is stalled by holding OPB_SELECT until ack; OPB_CAN_ERRACK_EN makes invalid channels return errAck.
module opb_can_bridge #(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter int          RD_LAT     = 2,
  parameter int          WR_LAT     = 0
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        OPB_SELECT,
  input  logic        OPB_RNW,
  input  logic [31:0] OPB_ABUS,
  input  logic [31:0] OPB_DBUS,
  output logic [31:0] Sl_DBUS,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic [15:0] CAN_ADDR,
  output logic [31:0] CAN_DI,
  output logic        CAN1_RE,
  output logic        CAN2_RE,
  output logic        CAN3_RE,
  output logic        CAN4_RE,
  output logic        CAN1_WE,
  output logic        CAN2_WE,
  output logic        CAN3_WE,
  output logic        CAN4_WE,
  input  logic [31:0] CAN1_DO,
  input  logic [31:0] CAN2_DO,
  input  logic [31:0] CAN3_DO,
  input  logic [31:0] CAN4_DO
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STROBE = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACK    = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
`ifdef OPB_CAN_ERRACK_EN
  localparam logic [2:0] S_ERR    = 3'd5;
`endif

  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LAT);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rnw_q, rnw_d;
  logic [3:0]  chan_q, chan_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] di_q, di_d;
  logic [3:0]  re_q, re_d;
  logic [3:0]  we_q, we_d;
  logic        xfer_ack_q, xfer_ack_d;
  logic        err_ack_q, err_ack_d;
  logic [31:0] dbus_q, dbus_d;

  logic        base_hit;
  logic [3:0]  chan_in;
  logic        chan_ok;
  logic        wait_done;
  logic [31:0] rd_mux;

  assign base_hit = (OPB_ABUS[31:15] == C_BASEADDR[31:15]);
  assign chan_in  = OPB_ABUS[14:11];
  assign chan_ok  = (chan_in == 4'b0001) || (chan_in == 4'b0010) ||
                    (chan_in == 4'b0100) || (chan_in == 4'b1000);
  // Reads count RD_LAT-1 down to 0; writes count WR_LAT down to 1 so both spend exactly *_LAT cycles in WAIT.
  assign wait_done = rnw_q ? (cnt_q == 4'd0) : (cnt_q == 4'd1);

  always_comb begin
    rd_mux = 32'd0;
    case (chan_q)
      4'b0001: rd_mux = CAN1_DO;
      4'b0010: rd_mux = CAN2_DO;
      4'b0100: rd_mux = CAN3_DO;
      4'b1000: rd_mux = CAN4_DO;
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rnw_d      = rnw_q;
    chan_d     = chan_q;
    addr_d     = addr_q;
    di_d       = di_q;
    re_d       = 4'd0;
    we_d       = 4'd0;
    xfer_ack_d = 1'b0;
    err_ack_d  = 1'b0;
    dbus_d     = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (OPB_SELECT && base_hit) begin
          if (chan_ok) begin
            state_d = S_STROBE;
            rnw_d   = OPB_RNW;
            chan_d  = chan_in;
            addr_d  = OPB_ABUS[15:0];
            di_d    = OPB_DBUS;
            if (OPB_RNW) re_d = chan_in;
            else         we_d = chan_in;
          end
`ifdef OPB_CAN_ERRACK_EN
          else begin
            state_d    = S_ERR;
            xfer_ack_d = 1'b1;
            err_ack_d  = 1'b1;
          end
`endif
        end
      end

      S_STROBE: begin
        if (!OPB_SELECT) begin
          state_d = S_IDLE;
        end else if (rnw_q) begin
          state_d = S_WAIT;
          cnt_d   = RD_LOAD;
        end else if (WR_LAT == 0) begin
          state_d    = S_ACK;
          xfer_ack_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WR_LOAD;
        end
      end

      S_WAIT: begin
        if (!OPB_SELECT) begin
          state_d = S_IDLE;
        end else if (wait_done) begin
          state_d    = S_ACK;
          xfer_ack_d = 1'b1;
          dbus_d     = rnw_q ? rd_mux : 32'd0;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ACK: begin
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (!OPB_SELECT) state_d = S_IDLE;
      end

`ifdef OPB_CAN_ERRACK_EN
      S_ERR: begin
        state_d = S_HOLD;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rnw_q      <= 1'b0;
      chan_q     <= 4'd0;
      addr_q     <= 16'd0;
      di_q       <= 32'd0;
      re_q       <= 4'd0;
      we_q       <= 4'd0;
      xfer_ack_q <= 1'b0;
      err_ack_q  <= 1'b0;
      dbus_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rnw_q      <= rnw_d;
      chan_q     <= chan_d;
      addr_q     <= addr_d;
      di_q       <= di_d;
      re_q       <= re_d;
      we_q       <= we_d;
      xfer_ack_q <= xfer_ack_d;
      err_ack_q  <= err_ack_d;
      dbus_q     <= dbus_d;
    end
  end

  assign Sl_DBUS    = dbus_q;
  assign Sl_xferAck = xfer_ack_q;
  assign Sl_errAck  = err_ack_q;
  assign CAN_ADDR   = addr_q;
  assign CAN_DI     = di_q;
  assign CAN1_RE    = re_q[0];
  assign CAN2_RE    = re_q[1];
  assign CAN3_RE    = re_q[2];
  assign CAN4_RE    = re_q[3];
  assign CAN1_WE    = we_q[0];
  assign CAN2_WE    = we_q[1];
  assign CAN3_WE    = we_q[2];
  assign CAN4_WE    = we_q[3];

endmodule

// File: tb/tb_opb_can_bridge.sv
// Bench for opb_can_bridge: directed bus cycles followed by randomized ones, each checked cycle by cycle.
module tb_opb_can_bridge;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 0;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        rnw;
  logic [31:0] abus;
  logic [31:0] wbus;
  logic [31:0] sl_dbus;
  logic        xfer_ack;
  logic        err_ack;
  logic [15:0] can_addr;
  logic [31:0] can_di;
  logic [3:0]  re;
  logic [3:0]  we;
  logic [31:0] can_do [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opb_can_bridge #(
    .C_BASEADDR(BASE),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT)
  ) dut (
    .OPB_CLK   (clk),
    .OPB_RST   (rst),
    .OPB_SELECT(sel),
    .OPB_RNW   (rnw),
    .OPB_ABUS  (abus),
    .OPB_DBUS  (wbus),
    .Sl_DBUS   (sl_dbus),
    .Sl_xferAck(xfer_ack),
    .Sl_errAck (err_ack),
    .CAN_ADDR  (can_addr),
    .CAN_DI    (can_di),
    .CAN1_RE   (re[0]),
    .CAN2_RE   (re[1]),
    .CAN3_RE   (re[2]),
    .CAN4_RE   (re[3]),
    .CAN1_WE   (we[0]),
    .CAN2_WE   (we[1]),
    .CAN3_WE   (we[2]),
    .CAN4_WE   (we[3]),
    .CAN1_DO   (can_do[0]),
    .CAN2_DO   (can_do[1]),
    .CAN3_DO   (can_do[2]),
    .CAN4_DO   (can_do[3])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " strobes"}, {24'd0, we, re}, 32'd0);
    check({tag, " xferAck"}, {31'd0, xfer_ack}, 32'd0);
    check({tag, " errAck"}, {31'd0, err_ack}, 32'd0);
    check({tag, " Sl_DBUS"}, sl_dbus, 32'd0);
    check({tag, " CAN_ADDR"}, {16'd0, can_addr}, 32'd0);
    check({tag, " CAN_DI"}, can_di, 32'd0);
  endtask

  // Reference: a legal one-hot channel strobes in cycle 1 and acks at LAT+2; anything else never strobes.
  task automatic txn(input logic [31:0] addr, input logic rd, input logic [31:0] wdata, input int abort_at);
    logic [3:0]  oh;
    logic        hit;
    logic        valid;
    logic        err_exp;
    logic [31:0] rd_exp;
    logic [31:0] strobe_exp;
    int          ack_at;
    int          last;
    hit     = (addr[31:15] == BASE[31:15]);
    oh      = addr[14:11];
    valid   = hit && (oh == 4'd1 || oh == 4'd2 || oh == 4'd4 || oh == 4'd8);
    err_exp = 1'b0;
    ack_at  = -1;
    rd_exp  = 32'd0;
    for (int c = 0; c < 4; c++) if (oh == 4'(1 << c)) rd_exp = can_do[c];
    if (valid) ack_at = rd ? RD_LAT + 2 : WR_LAT + 2;
`ifdef OPB_CAN_ERRACK_EN
    else if (hit) begin
      ack_at  = 1;
      err_exp = 1'b1;
    end
`endif
    if (abort_at >= 1 && abort_at < ack_at) ack_at = -1;
    last = (ack_at >= 0) ? ack_at + 1 : 20;
    strobe_exp = rd ? {28'd0, oh} : {24'd0, oh, 4'd0};

    @(posedge clk); #1;
    sel  = 1'b1;
    abus = addr;
    rnw  = rd;
    wbus = wdata;
    for (int k = 0; k <= last; k++) begin
      if (k == abort_at || (ack_at >= 0 && k == ack_at + 1)) sel = 1'b0;
      @(negedge clk);
      check($sformatf("strobes a=%h c%0d", addr, k), {24'd0, we, re},
            (k == 1 && valid) ? strobe_exp : 32'd0);
      check($sformatf("xferAck a=%h c%0d", addr, k), {31'd0, xfer_ack}, {31'd0, k == ack_at});
      check($sformatf("errAck a=%h c%0d", addr, k), {31'd0, err_ack},
            {31'd0, err_exp && k == ack_at});
      check($sformatf("Sl_DBUS a=%h c%0d", addr, k), sl_dbus,
            (k == ack_at && valid && rd) ? rd_exp : 32'd0);
      if (valid && (k == 1 || k == ack_at)) begin
        check($sformatf("CAN_ADDR a=%h c%0d", addr, k), {16'd0, can_addr}, {16'd0, addr[15:0]});
        check($sformatf("CAN_DI a=%h c%0d", addr, k), can_di, wdata);
      end
      @(posedge clk); #1;
    end
    sel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  pat;
    logic [16:0] upper;
    logic        rd;
    int          kind;
    int          ab;
    int          full;

    rst  = 1'b1;
    sel  = 1'b0;
    rnw  = 1'b0;
    abus = 32'd0;
    wbus = 32'd0;
    for (int c = 0; c < 4; c++) can_do[c] = 32'hA000_0000 + 32'(c);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset state");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases from the test plan.
    txn(32'h0000_0800, 1'b0, 32'h1234_5678, -1);
    can_do[2] = 32'h55AA_55AA;
    txn(32'h0000_2000, 1'b1, 32'h0, -1);
    txn(32'h0000_1800, 1'b1, 32'h0, -1);
    txn(32'h0001_0800, 1'b0, 32'hDEAD_BEEF, -1);
    can_do[3] = 32'hCAFE_F00D;
    txn(32'h0000_4000, 1'b1, 32'h0, 2);
    txn(32'h0000_1000, 1'b0, 32'h0BAD_F00D, -1);

    // Reset in WAIT of a CAN2 read.
    can_do[1] = 32'h1357_9BDF;
    @(posedge clk); #1;
    sel  = 1'b1;
    rnw  = 1'b1;
    abus = 32'h0000_1000;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst-test strobe c1", {24'd0, we, re}, 32'h0000_0002);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst-test xferAck c2", {31'd0, xfer_ack}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    check_zero("after reset");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("post-reset xferAck %0d", k), {31'd0, xfer_ack}, 32'd0);
    end
    txn(32'h0000_1000, 1'b1, 32'h0, -1);

    // Randomized bus cycles.
    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < 4; c++) can_do[c] = $urandom;
      kind = $urandom_range(0, 9);
      rd   = 1'($urandom_range(0, 1));
      ab   = -1;
      if (kind <= 5) begin
        a = {BASE[31:15], 4'(1 << $urandom_range(0, 3)), 11'($urandom)};
        if ($urandom_range(0, 3) == 0) begin
          full = rd ? RD_LAT + 2 : WR_LAT + 2;
          ab   = $urandom_range(1, full - 1);
        end
      end else if (kind <= 7) begin
        do pat = 4'($urandom);
        while (pat == 4'd1 || pat == 4'd2 || pat == 4'd4 || pat == 4'd8);
        a = {BASE[31:15], pat, 11'($urandom)};
      end else begin
        upper = BASE[31:15] ^ 17'($urandom_range(1, 17'h1FFFF));
        a = {upper, 15'($urandom)};
      end
      txn(a, rd, $urandom, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_can_bridge.md
Name: opb_can_bridge

Overview:
OPB slave front-end that sits directly upstream of the four-channel CAN interface block. It decodes OPB transactions into one-hot CAN1..CAN4 read/write strobes and presents a stable address and write data. It inserts programmable wait states, captures the selected channel's read data, and returns xferAck/errAck to the OPB master. It replaces direct strobe wiring from the bus.

Parameters:
C_BASEADDR, 32'h0000_0000, block base; OPB_ABUS[31:15] compared against C_BASEADDR[31:15]
RD_LAT, 2, cycles from RE strobe to read-data capture (legal 1..15)
WR_LAT, 0, extra wait cycles after WE strobe before ack (legal 0..15)

Ports:
OPB_CLK  in  1  bus clock; all logic rising-edge
OPB_RST  in  1  synchronous, active-high reset
OPB_SELECT  in  1  master select, held until ack
OPB_RNW  in  1  1=read, 0=write
OPB_ABUS  in  32  byte address
OPB_DBUS  in  32  write data from master
Sl_DBUS  out  32  read data, nonzero only in ack cycle
Sl_xferAck  out  1  one-cycle transfer acknowledge
Sl_errAck  out  1  one-cycle error acknowledge (see Optional Feature)
CAN_ADDR  out  16  registered OPB_ABUS[15:0] to CAN block
CAN_DI  out  32  registered write data to CAN block
CAN1_RE, CAN2_RE, CAN3_RE, CAN4_RE  out  1 each  read strobes
CAN1_WE, CAN2_WE, CAN3_WE, CAN4_WE  out  1 each  write strobes
CAN1_DO, CAN2_DO, CAN3_DO, CAN4_DO  in  32 each  channel read data

Behaviour:
- Reset: all outputs 0; state IDLE; wait counter 0. Reset asserted in any state takes effect at the next edge, with no ack and no strobe issued. A strobe already issued is not retracted.
- Decode: base hit = OPB_ABUS[31:15]==C_BASEADDR[31:15]. Channel = OPB_ABUS[14:11], which must be one-hot: 0001=CAN1, 0010=CAN2, 0100=CAN3, 1000=CAN4. Any other pattern is invalid.
- FSM IDLE -> STROBE -> WAIT -> ACK -> HOLD -> IDLE.
- IDLE: with OPB_SELECT=1, base hit and valid channel (cycle 0), register ABUS[15:0], DBUS, RNW and channel, then go to STROBE. A base miss is ignored and the FSM stays in IDLE.
- STROBE (cycle 1): exactly one CANx_RE (read) or CANx_WE (write) is high for this single cycle. CAN_ADDR and CAN_DI are valid from cycle 1 and held until leaving ACK. Load the counter with RD_LAT-1 (read) or WR_LAT (write).
- WAIT: decrement the counter each cycle.
  - Read: at counter==0, capture the selected CANx_DO and go to ACK. Data is sampled at the edge ending cycle 1+RD_LAT.
  - Write with WR_LAT=0: WAIT is skipped.
- ACK: Sl_xferAck=1 for one cycle. Sl_DBUS = captured data for a read, 0 for a write. Next state is HOLD.
  - Read ack cycle = RD_LAT+2 (default 4).
  - Write ack cycle = WR_LAT+2 (default 2).
- HOLD: stay until OPB_SELECT=0, then go to IDLE. This prevents re-triggering on a held select.
- Abort: OPB_SELECT=0 in STROBE or WAIT returns to IDLE next cycle, with no ack and no data capture.
- Sl_DBUS, Sl_xferAck and Sl_errAck are 0 in every cycle other than the ack cycle.
- Back-to-back transactions: minimum one IDLE cycle between transactions.

Optional Feature:
Macro OPB_CAN_ERRACK_EN.
- Defined: IDLE with OPB_SELECT=1, base hit and invalid channel goes to an ERR state. ERR drives Sl_errAck=1 and Sl_xferAck=1 for one cycle (cycle 1), with no strobe, then goes to HOLD.
- Undefined: an invalid channel is ignored like a base miss. There is no ack, and the master times out.

Test Plan:
- Write to CAN1 at 0x0000_0800, data 0x12345678 -> CAN1_WE=1 only in cycle 1 with CAN_ADDR=0x0800 and CAN_DI=0x12345678; xferAck in cycle 2; all other strobes stay 0.
- Read from CAN3 at 0x0000_2000 with CAN3_DO=0x55AA55AA -> CAN3_RE in cycle 1; xferAck in cycle 4 with Sl_DBUS=0x55AA55AA; Sl_DBUS=0 in every other cycle.
- Invalid decode at 0x0000_1800 -> no strobes. With the macro: errAck and xferAck in cycle 1. Without the macro: no ack for 20 cycles.
- Base miss at 0x0001_0800 (C_BASEADDR=0) -> no strobe, no ack.
- Abort: read CAN4 at 0x4000, drop OPB_SELECT in cycle 2 -> no ack; FSM back in IDLE in cycle 3; a following write to CAN2 at 0x1000 completes normally.
- Reset in WAIT of a CAN2 read -> all outputs 0 after the next edge; no ack; next transaction succeeds.
